// File: rtl/code_entry_fsm.sv
// Password-entry FSM: builds a BCD code from inc/next key pulses, checks it on enter,
// and enforces a timed lockout after MAX_TRIES wrong submissions.
module code_entry_fsm #(
    parameter int unsigned             DIGITS      = 4,
    parameter logic [4*DIGITS-1:0]     CODE        = 16'h1234,
    parameter int unsigned             MAX_TRIES   = 3,
    parameter int unsigned             LOCK_CYCLES = 250_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        key_inc,
    input  logic                        key_next,
    input  logic                        key_enter,
    input  logic                        key_clear,
    output logic [4*DIGITS-1:0]         digits,
    output logic [$clog2(DIGITS)-1:0]   cur_pos,
    output logic                        unlocked,
    output logic                        fail_pulse,
    output logic                        locked_out,
    output logic [3:0]                  tries_left
);
    localparam int unsigned POS_W = $clog2(DIGITS);

    typedef enum logic [1:0] {
        ENTRY,
        UNLOCKED,
        LOCKOUT
    } state_e;

    state_e                 state_q, state_d;
    logic [4*DIGITS-1:0]    digits_q, digits_d;
    logic [POS_W-1:0]       cur_pos_q, cur_pos_d;
    logic                   unlocked_q, unlocked_d;
    logic                   fail_pulse_q, fail_pulse_d;
    logic                   locked_out_q, locked_out_d;
    logic [3:0]             tries_left_q, tries_left_d;
    logic [31:0]            lock_cnt_q, lock_cnt_d;

    always_comb begin
        state_d      = state_q;
        digits_d     = digits_q;
        cur_pos_d    = cur_pos_q;
        fail_pulse_d = 1'b0;
        tries_left_d = tries_left_q;
        lock_cnt_d   = lock_cnt_q;

        case (state_q)
            ENTRY: begin
                // Priority chain: clear > enter > next > inc.
                if (key_clear) begin
                    digits_d  = '0;
                    cur_pos_d = '0;
                end else if (key_enter) begin
                    if (digits_q == CODE) begin
                        state_d      = UNLOCKED;
                        tries_left_d = 4'(MAX_TRIES);
                    end else begin
                        fail_pulse_d = 1'b1;
                        digits_d     = '0;
                        cur_pos_d    = '0;
                        if (tries_left_q <= 4'd1) begin
                            tries_left_d = '0;
                            state_d      = LOCKOUT;
                            lock_cnt_d   = 32'(LOCK_CYCLES - 1);
                        end else begin
                            tries_left_d = tries_left_q - 4'd1;
                        end
                    end
                end else if (key_next) begin
                    if (cur_pos_q == POS_W'(DIGITS - 1)) begin
                        cur_pos_d = '0;
                    end else begin
                        cur_pos_d = cur_pos_q + POS_W'(1);
                    end
                end else if (key_inc) begin
                    for (int unsigned i = 0; i < DIGITS; i++) begin
                        if (cur_pos_q == POS_W'(i)) begin
                            digits_d[4*i +: 4] = (digits_q[4*i +: 4] == 4'd9) ? 4'd0
                                                 : digits_q[4*i +: 4] + 4'd1;
                        end
                    end
                end
            end
            UNLOCKED: begin
                if (key_clear) begin
                    state_d   = ENTRY;
                    digits_d  = '0;
                    cur_pos_d = '0;
                end
            end
            LOCKOUT: begin
                if (lock_cnt_q == '0) begin
                    state_d      = ENTRY;
                    tries_left_d = 4'(MAX_TRIES);
                    digits_d     = '0;
                    cur_pos_d    = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q - 32'd1;
                end
            end
            default: state_d = ENTRY;
        endcase

        unlocked_d   = (state_d == UNLOCKED);
        locked_out_d = (state_d == LOCKOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ENTRY;
            digits_q     <= '0;
            cur_pos_q    <= '0;
            unlocked_q   <= 1'b0;
            fail_pulse_q <= 1'b0;
            locked_out_q <= 1'b0;
            tries_left_q <= 4'(MAX_TRIES);
            lock_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            digits_q     <= digits_d;
            cur_pos_q    <= cur_pos_d;
            unlocked_q   <= unlocked_d;
            fail_pulse_q <= fail_pulse_d;
            locked_out_q <= locked_out_d;
            tries_left_q <= tries_left_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

    assign digits     = digits_q;
    assign cur_pos    = cur_pos_q;
    assign unlocked   = unlocked_q;
    assign fail_pulse = fail_pulse_q;
    assign locked_out = locked_out_q;
    assign tries_left = tries_left_q;

endmodule

// File: tb/tb_code_entry_fsm.sv
// Bench for code_entry_fsm: directed scenarios plus random key traffic, all outputs
// compared every cycle against an arithmetic model of the code-entry rules.
module tb_code_entry_fsm;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_inc = 1'b0, key_next = 1'b0, key_enter = 1'b0, key_clear = 1'b0;
    logic [15:0] digits;
    logic [1:0]  cur_pos;
    logic        unlocked, fail_pulse, locked_out;
    logic [3:0]  tries_left;

    code_entry_fsm #(
        .DIGITS      (4),
        .CODE        (16'h1234),
        .MAX_TRIES   (3),
        .LOCK_CYCLES (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_inc    (key_inc),
        .key_next   (key_next),
        .key_enter  (key_enter),
        .key_clear  (key_clear),
        .digits     (digits),
        .cur_pos    (cur_pos),
        .unlocked   (unlocked),
        .fail_pulse (fail_pulse),
        .locked_out (locked_out),
        .tries_left (tries_left)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: digits as plain integers, mode as flags, lockout as cycles remaining.
    int m_dig[4];
    int m_pos, m_tries, m_lockrem;
    bit m_unl, m_fail, m_lock;

    function automatic logic [15:0] m_packed();
        int v = 0;
        for (int i = 3; i >= 0; i--) v = v * 16 + m_dig[i];
        return 16'(v);
    endfunction

    task automatic m_zero_entry();
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_pos = 0;
    endtask

    task automatic m_update(input bit r, input bit i, input bit n, input bit e, input bit c);
        m_fail = 0;
        if (r) begin
            m_zero_entry();
            m_unl = 0; m_lock = 0; m_tries = 3; m_lockrem = 0;
        end else if (m_lock) begin
            m_lockrem--;
            if (m_lockrem == 0) begin
                m_lock = 0; m_tries = 3; m_zero_entry();
            end
        end else if (m_unl) begin
            if (c) begin m_unl = 0; m_zero_entry(); end
        end else if (c) begin
            m_zero_entry();
        end else if (e) begin
            if (m_packed() == 16'h1234) begin
                m_unl = 1; m_tries = 3;
            end else begin
                m_fail = 1; m_zero_entry(); m_tries--;
                if (m_tries == 0) begin m_lock = 1; m_lockrem = 100; end
            end
        end else if (n) begin
            m_pos = (m_pos + 1) % 4;
        end else if (i) begin
            m_dig[m_pos] = (m_dig[m_pos] + 1) % 10;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all();
        check("digits",     32'(digits),     32'(m_packed()));
        check("cur_pos",    32'(cur_pos),    32'(m_pos));
        check("unlocked",   32'(unlocked),   32'(m_unl));
        check("fail_pulse", 32'(fail_pulse), 32'(m_fail));
        check("locked_out", 32'(locked_out), 32'(m_lock));
        check("tries_left", 32'(tries_left), 32'(m_tries));
    endtask

    task automatic step(input bit r, input bit i, input bit n, input bit e, input bit c);
        rst = r; key_inc = i; key_next = n; key_enter = e; key_clear = c;
        @(posedge clk);
        m_update(r, i, n, e, c);
        #1;
        check_all();
    endtask

    task automatic enter_code_1234();
        for (int d = 0; d < 4; d++) begin
            repeat (4 - d) step(0, 1, 0, 0, 0);
            if (d < 3) step(0, 0, 1, 0, 0);
        end
    endtask

    initial begin
        int lock_hi;
        m_zero_entry();
        m_unl = 0; m_lock = 0; m_fail = 0; m_tries = 3; m_lockrem = 0;
        @(negedge clk);

        // Reset state
        step(1, 0, 0, 0, 0);
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_tries",  32'(tries_left), 32'd3);

        // Correct code: digit positions 0..3 get 4,3,2,1
        enter_code_1234();
        step(0, 0, 0, 1, 0);
        check("unlock_digits", 32'(digits), 32'h1234);
        check("unlock_flag",   32'(unlocked), 32'd1);
        step(0, 1, 1, 1, 0);            // ignored while unlocked
        step(0, 0, 0, 0, 1);            // clear disarms
        check("disarm", 32'(unlocked), 32'd0);

        // Reset while unlocked
        enter_code_1234();
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        check("rst_unlocked", 32'(unlocked), 32'd0);

        // Wraps and clear
        repeat (10) step(0, 1, 0, 0, 0);
        check("digit_wrap", 32'(digits), 32'h0);
        repeat (4) step(0, 0, 1, 0, 0);
        check("pos_wrap", 32'(cur_pos), 32'd0);
        repeat (3) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("clear", 32'(digits), 32'h0);

        // Wrong code
        step(0, 0, 0, 1, 0);
        check("wrong_fail",  32'(fail_pulse), 32'd1);
        check("wrong_tries", 32'(tries_left), 32'd2);
        step(0, 0, 0, 0, 0);
        check("fail_one_cycle", 32'(fail_pulse), 32'd0);

        // Simultaneous keys
        step(1, 0, 0, 0, 0);
        enter_code_1234();
        step(0, 0, 0, 1, 1);
        check("clr_enter_unl", 32'(unlocked), 32'd0);
        check("clr_enter_dig", 32'(digits), 32'h0);
        step(0, 1, 1, 0, 0);
        check("next_inc_pos", 32'(cur_pos), 32'd1);
        check("next_inc_dig", 32'(digits), 32'h0);

        // Lockout duration, keys ignored during it
        step(1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 1, 0);
        lock_hi = 0;
        if (locked_out) lock_hi++;
        repeat (99) begin
            step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if (locked_out) lock_hi++;
        end
        step(0, 0, 0, 0, 0);
        if (locked_out) lock_hi++;
        check("lock_len", 32'(lock_hi), 32'd100);
        check("lock_tries", 32'(tries_left), 32'd3);
        step(0, 1, 0, 0, 0);
        check("post_lock_inc", 32'(digits), 32'h1);

        // Reset at lockout cycle 50
        repeat (3) step(0, 0, 0, 1, 0);
        repeat (48) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rst_lock_flag",  32'(locked_out), 32'd0);
        check("rst_lock_tries", 32'(tries_left), 32'd3);

        // Random traffic
        repeat (1500) begin
            step(($urandom % 200) == 0, ($urandom % 2) == 0, ($urandom % 4) == 0,
                 ($urandom % 8) == 0, ($urandom % 16) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
